// File: rtl/sram_arbiter.sv
// N-channel SRAM arbiter/sequencer: IDLE -> ADDR -> STROBE(WR_CYC) -> DONE, request-to-ack 2+WR_CYC clocks.
// Channel 0 always wins; channels 1..N-1 rotate when SRAM_ARB_RR_EN is defined, else lowest index wins.
module sram_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int WR_CYC   = 2
) (
  input  logic                         clk28,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          req,
  input  logic [CHANNELS-1:0]          wr,
  input  logic [CHANNELS*ADDR_W-1:0]   addr,
  input  logic [CHANNELS*DATA_W-1:0]   wdata,
  output logic [CHANNELS-1:0]          ack,
  output logic [DATA_W-1:0]            rdata,
  output logic                         busy,
  output logic [$clog2(CHANNELS)-1:0]  grant_id,
  output logic [ADDR_W-1:0]            va,
  inout  wire  [DATA_W-1:0]            vd,
  output logic                         n_vwr,
  output logic                         n_vrd
);

  localparam int IW = $clog2(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_wr;
  logic [DATA_W-1:0] lat_wdata;
  logic              vd_oe;

  logic [IW-1:0]     win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wr;

`ifdef SRAM_ARB_RR_EN
  logic [IW-1:0]     ptr;
`endif

  // Winner: ch0 first; otherwise lowest requester at/above the pointer, else lowest overall.
  always_comb begin
    win = '0;
    if (!req[0]) begin
      for (int i = CHANNELS - 1; i >= 1; i--) begin
        if (req[i]) win = IW'(i);
      end
`ifdef SRAM_ARB_RR_EN
      for (int i = CHANNELS - 1; i >= 1; i--) begin
        if (req[i] && i >= int'(ptr)) win = IW'(i);
      end
`endif
    end
  end

  always_comb begin
    sel_addr  = addr[int'(win)*ADDR_W +: ADDR_W];
    sel_wdata = wdata[int'(win)*DATA_W +: DATA_W];
    sel_wr    = wr[win];
  end

  assign vd = vd_oe ? lat_wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk28) begin
    if (rst) begin
      state     <= S_IDLE;
      ack       <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      n_vwr     <= 1'b1;
      n_vrd     <= 1'b1;
      va        <= '0;
      rdata     <= '0;
      vd_oe     <= 1'b0;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr       <= IW'(1);
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ack <= '0;
          if (|req) begin
            state     <= S_ADDR;
            busy      <= 1'b1;
            grant_id  <= win;
            va        <= sel_addr;
            lat_wr    <= sel_wr;
            lat_wdata <= sel_wdata;
            vd_oe     <= sel_wr;
            n_vrd     <= sel_wr;
`ifdef SRAM_ARB_RR_EN
            if (win != '0) ptr <= (int'(win) == CHANNELS - 1) ? IW'(1) : win + IW'(1);
`endif
          end
        end
        S_ADDR: begin
          state <= S_STROBE;
          cnt   <= 4'(WR_CYC - 1);
          n_vwr <= ~lat_wr;
        end
        S_STROBE: begin
          if (cnt == 4'd0) begin
            state <= S_DONE;
            n_vwr <= 1'b1;
            n_vrd <= 1'b1;
            ack   <= CHANNELS'(1) << grant_id;
            if (!lat_wr) rdata <= vd;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          // Write data stays on vd through this cycle for hold time.
          state <= S_IDLE;
          ack   <= '0;
          busy  <= 1'b0;
          vd_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model checked every cycle, directed scenarios, random traffic, WR_CYC sweep.
module tb_sram_arbiter;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int W  = 2;

  logic clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  logic            rst;
  logic [N-1:0]    req, wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [1:0]      grant_id;
  logic [AW-1:0]   va;
  wire  [DW-1:0]   vd;
  logic            n_vwr, n_vrd;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  sram_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW), .WR_CYC(W)) dut (
    .clk28(clk28), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .va(va), .vd(vd), .n_vwr(n_vwr), .n_vrd(n_vrd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[18:11];
  endfunction

  // SRAM device
  logic [7:0] sram [int];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk28) if (n_vwr === 1'b0) sram[int'(va)] = vd;
  always @(negedge clk28) sram_q = sram.exists(int'(va)) ? sram[int'(va)] : init_val(va);
  assign vd = (n_vrd === 1'b0) ? sram_q : 8'bz;

  // Transaction-level model
  logic [7:0] shadow [int];
  bit            m_act   = 1'b0;
  int            m_off   = 0;
  int            m_ch    = 0;
  bit            m_wr    = 1'b0;
  logic [AW-1:0] m_va    = '0;
  logic [DW-1:0] m_wd    = '0;
  logic [DW-1:0] m_rd    = '0;
  int            m_ptr   = 1;
  int            m_grant = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    if (r[0]) return 0;
`ifdef SRAM_ARB_RR_EN
    for (int i = 0; i < N - 1; i++) begin
      int c;
      c = ((p - 1 + i) % (N - 1)) + 1;
      if (r[c]) return c;
    end
`else
    for (int c = 1; c < N; c++) if (r[c]) return c;
`endif
    return 0;
  endfunction

  always @(posedge clk28) begin
    if (rst) begin
      m_act = 1'b0; m_off = 0; m_ptr = 1; m_rd = '0; m_va = '0; m_grant = 0;
    end else if (m_act) begin
      m_off++;
      if (m_off == 2 + W) begin
        if (m_wr) shadow[int'(m_va)] = m_wd;
        else m_rd = shadow.exists(int'(m_va)) ? shadow[int'(m_va)] : init_val(m_va);
      end
      if (m_off == 3 + W) m_act = 1'b0;
    end else if (req != '0) begin
      m_ch    = pick(req, m_ptr);
      m_act   = 1'b1;
      m_off   = 1;
      m_wr    = wr[m_ch];
      m_va    = addr[m_ch*AW +: AW];
      m_wd    = wdata[m_ch*DW +: DW];
      m_grant = m_ch;
      if (m_ch != 0) m_ptr = (m_ch == N - 1) ? 1 : m_ch + 1;
    end
  end

  always @(negedge clk28) begin : cmp
    logic [N-1:0] e_ack;
    if (chk_en) begin
      e_ack = (m_act && m_off == 2 + W) ? (N'(1) << m_ch) : '0;
      check("busy", busy, m_act);
      check("ack", ack, e_ack);
      check("va", va, m_va);
      check("rdata", rdata, m_rd);
      check("n_vwr", n_vwr, !(m_act && m_wr && m_off >= 2 && m_off <= 1 + W));
      check("n_vrd", n_vrd, !(m_act && !m_wr && m_off <= 1 + W));
      if (m_act) check("grant_id", grant_id, m_grant);
      if (m_act && m_wr) check("vd", vd, m_wd);
    end
  end

  task automatic set_ch(input int c, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = r;
    wr[c]  = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic new_access(input int c);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
    set_ch(c, 1'b1, 1'($urandom_range(0, 1)), a, DW'($urandom));
  endtask

  task automatic wait_ack(input int c, output int lat, output int low);
    lat = 0;
    low = 0;
    while (lat < 100) begin
      @(negedge clk28);
      lat++;
      if (n_vwr === 1'b0) low++;
      if (ack[c] === 1'b1) break;
    end
    if (ack[c] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout ch%0d: no ack within %0d cycles", c, lat);
    end
  endtask

  task automatic wait_any(output int ch);
    int n;
    ch = -1;
    n  = 0;
    while (n < 100 && ch < 0) begin
      @(negedge clk28);
      n++;
      for (int i = N - 1; i >= 0; i--) if (ack[i] === 1'b1) ch = i;
    end
    if (ch < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: no ack within %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk28);
    rst = 1'b0;
  endtask

  // WR_CYC sweep on two small instances
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 1 : 15;
    logic            s_rst;
    logic [1:0]      s_req, s_wr, s_ack;
    logic [2*AW-1:0] s_addr;
    logic [2*DW-1:0] s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            s_busy;
    logic [0:0]      s_gid;
    logic [AW-1:0]   s_va;
    wire  [DW-1:0]   s_vd;
    logic            s_nvwr, s_nvrd;
    bit              done = 1'b0;

    sram_arbiter #(.CHANNELS(2), .ADDR_W(AW), .DATA_W(DW), .WR_CYC(SW)) u_dut (
      .clk28(clk28), .rst(s_rst), .req(s_req), .wr(s_wr), .addr(s_addr), .wdata(s_wdata),
      .ack(s_ack), .rdata(s_rdata), .busy(s_busy), .grant_id(s_gid),
      .va(s_va), .vd(s_vd), .n_vwr(s_nvwr), .n_vrd(s_nvrd)
    );

    initial begin : run
      int lat, low;
      s_rst = 1'b1; s_req = '0; s_wr = '0; s_addr = '0; s_wdata = '0;
      repeat (2) @(negedge clk28);
      check($sformatf("sweep%0d_rst_busy", SW), s_busy, 1'b0);
      check($sformatf("sweep%0d_rst_rdata", SW), s_rdata, 8'h00);
      s_rst = 1'b0;
      s_req = 2'b10; s_wr = 2'b10;
      s_addr[AW +: AW] = 19'h00777; s_wdata[DW +: DW] = 8'hC3;
      lat = 0; low = 0;
      while (lat < 100 && s_ack[1] !== 1'b1) begin
        @(negedge clk28);
        lat++;
        if (s_nvwr === 1'b0) low++;
      end
      check($sformatf("sweep%0d_latency", SW), lat, 2 + SW);
      check($sformatf("sweep%0d_nvwr_low", SW), low, SW);
      check($sformatf("sweep%0d_va", SW), s_va, 19'h00777);
      check($sformatf("sweep%0d_vd", SW), s_vd, 8'hC3);
      check($sformatf("sweep%0d_gid", SW), s_gid, 1'b1);
      s_req = '0;
      done = 1'b1;
    end
  end

  initial begin : main
    int lat, low, ch, t0, t1;
    int exp_seq [4];
    sram[int'(19'h7FFFF)]   = 8'h3C;
    shadow[int'(19'h7FFFF)] = 8'h3C;
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk28);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 4'h0);
    check("rst_n_vwr", n_vwr, 1'b1);
    check("rst_n_vrd", n_vrd, 1'b1);
    check("rst_va", va, 19'h0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_grant_id", grant_id, 2'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single write on ch2
    set_ch(2, 1'b1, 1'b1, 19'h12345, 8'hA5);
    wait_ack(2, lat, low);
    check("wr_latency", lat, 4);
    check("wr_nvwr_low", low, 2);
    check("wr_va", va, 19'h12345);
    check("wr_vd_hold", vd, 8'hA5);
    set_ch(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk28);

    // Single read on ch1
    set_ch(1, 1'b1, 1'b0, 19'h7FFFF, 8'h00);
    wait_ack(1, lat, low);
    check("rd_latency", lat, 4);
    check("rd_nvwr_low", low, 0);
    check("rd_rdata", rdata, 8'h3C);
    set_ch(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk28);

    // Contention on 1..3 from a fresh pointer, then ch0 joins
    do_reset();
`ifdef SRAM_ARB_RR_EN
    exp_seq = '{1, 2, 3, 1};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    set_ch(1, 1'b1, 1'b0, 19'h00101, 8'h00);
    set_ch(2, 1'b1, 1'b0, 19'h00202, 8'h00);
    set_ch(3, 1'b1, 1'b0, 19'h00303, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_any(ch);
      check($sformatf("contend_grant%0d", k), ch, exp_seq[k]);
    end
    set_ch(0, 1'b1, 1'b0, 19'h00020, 8'h00);
    wait_any(ch);
    check("contend_ch0_next", ch, 0);
    req = '0;
    @(negedge clk28);

    // Back-to-back writes on ch3
    set_ch(3, 1'b1, 1'b1, 19'h00040, 8'h5A);
    wait_ack(3, lat, low);
    check("b2b_first_latency", lat, 4);
    wait_ack(3, t0, low);
    check("b2b_period1", t0, 5);
    wait_ack(3, t1, low);
    check("b2b_period2", t1, 5);
    req = '0;
    @(negedge clk28);

    // Reset during STROBE of a write
    set_ch(2, 1'b1, 1'b1, 19'h55555, 8'h77);
    repeat (2) @(negedge clk28);
    check("abort_strobe_active", n_vwr, 1'b0);
    rst = 1'b1;
    @(negedge clk28);
    check("abort_n_vwr", n_vwr, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ack", ack, 4'h0);
    rst = 1'b0;
    wait_ack(2, lat, low);
    check("abort_retry_latency", lat, 4);
    check("abort_retry_nvwr_low", low, 2);
    req = '0;
    @(negedge clk28);

    // Random traffic following the handshake rules
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk28);
      for (int c = 0; c < N; c++) begin
        if (req[c] && ack[c] === 1'b1) begin
          if ($urandom_range(0, 1) == 1) new_access(c);
          else req[c] = 1'b0;
        end else if (!req[c] && $urandom_range(0, (c == 0) ? 7 : 3) == 0) begin
          new_access(c);
        end
      end
    end
    req = '0;
    repeat (W + 5) @(negedge clk28);

    for (int i = 0; i < 200 && !(g_sweep[0].done && g_sweep[1].done); i++) @(negedge clk28);
    if (!(g_sweep[0].done && g_sweep[1].done)) begin
      n_cmp++; n_bad++;
      $display("FAIL sweep_timeout: sweep instances did not finish");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised multi-channel arbiter and sequencer for the shared video/CPU SRAM. It generalises the single-master CPU/screen-fetch memory path into N request/acknowledge channels with a registered address/data path and a programmable write-strobe width. It sits between the requesters (screen fetch, CPU bus, palette writer, DMA) and the SRAM pins `va`/`vd`/`n_vwr`/`n_vrd`.

## Interface
Parameters:
- `CHANNELS`, default 4: number of requester channels, 2..8. Channel 0 is the video-fetch channel.
- `ADDR_W`, default 19: SRAM address width.
- `DATA_W`, default 8: SRAM data width.
- `WR_CYC`, default 2: STROBE state length in clocks, 1..15.

Ports (clock and reset first):
- `clk28` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input CHANNELS: per-channel request level.
- `wr` input CHANNELS: per-channel write (1) or read (0) qualifier.
- `addr` input CHANNELS*ADDR_W: per-channel address, packed; channel i occupies `[i*ADDR_W +: ADDR_W]`.
- `wdata` input CHANNELS*DATA_W: per-channel write data, packed the same way.
- `ack` output CHANNELS: one-clock completion pulse per channel.
- `rdata` output DATA_W: read data, shared by all channels, valid while `ack[i]` is high.
- `busy` output 1: high in every state except IDLE.
- `grant_id` output $clog2(CHANNELS): channel currently being served.
- `va` output ADDR_W: SRAM address.
- `vd` inout DATA_W: SRAM data.
- `n_vwr` output 1: SRAM write enable, active low.
- `n_vrd` output 1: SRAM output enable, active low.

## Operation
FSM states: IDLE, ADDR, STROBE, DONE.

- **IDLE**
  - If no `req` bit is set, stay in IDLE.
  - Otherwise pick a winner. Channel 0 always wins when requesting.
  - Among channels 1..N-1, selection depends on the configuration (see Configuration).
  - Latch the winner's `addr`, `wr` and `wdata` into internal registers, set `grant_id`, then go to ADDR.
- **ADDR** (1 clk)
  - `va` = latched address.
  - `n_vrd` = 0 for a read.
  - `vd` is driven with latched data for a write.
  - `n_vwr` stays 1. Go to STROBE.
- **STROBE** (WR_CYC clks)
  - For a write, `n_vwr` = 0.
  - For a read, `vd` is sampled into `rdata` on the last STROBE edge.
  - A down-counter loads WR_CYC-1 on entry; exit when it reaches 0.
- **DONE** (1 clk)
  - `ack[grant_id]` = 1. All other `ack` bits are 0.
  - `n_vwr` = 1. For a write, `vd` stays driven for hold time.
  - `n_vrd` = 1.
  - Always return to IDLE.

Handshake rules:
- A requester holds `req`, `wr`, `addr` and `wdata` stable until it sees `ack`.
- It drops `req` in the clock after `ack` unless it wants another access.
- A `req` still high during DONE is not an error; it is re-arbitrated in the following IDLE.
- `addr`, `wr` and `wdata` changes after the grant are ignored, because the latched copies are used.

Register values:
- `rdata` holds its last value until the next read completes.
- `va` holds its last value in IDLE.
- `vd` is high-Z in IDLE and throughout read accesses.

Reset (`rst` high at an edge): state = IDLE, `ack` = 0, `busy` = 0, `grant_id` = 0, `n_vwr` = 1, `n_vrd` = 1, `va` = 0, `rdata` = 0, `vd` = high-Z, round-robin pointer = 1.
- Reset during an access aborts it: no `ack` is issued and `n_vwr` returns to 1 at that edge.

## Timing
- Request-to-ack latency is 2+WR_CYC clocks. If `req` is first high at edge k, `ack` is high in the cycle after edge k+1+WR_CYC.
- Access period is 3+WR_CYC clocks, with a minimum of 1 IDLE clock between accesses.
- `n_vwr` low width = WR_CYC clocks.
- Address and data are stable 1 clk before `n_vwr` falls and 1 clk after it rises.
- Simultaneous requests: exactly one grant per IDLE visit, and channel 0 is never blocked by another channel for longer than one in-flight access.

## Configuration
`SRAM_ARB_RR_EN`:
- **Defined:** channels 1..N-1 use rotating priority. The pointer advances to grant+1 (wrapping N-1 → 1) after each non-zero grant, giving starvation-free service.
- **Undefined:** fixed priority, lowest index wins. No pointer register exists.

## Test plan
- Single write, CHANNELS=4, WR_CYC=2: ch2 writes `addr` 0x12345, `wdata` 0xA5 → `ack[2]` 4 clks after request; `n_vwr` low exactly 2 clks; `va`=0x12345 and `vd`=0xA5 from ADDR through DONE.
- Single read: SRAM model returns 0x3C at 0x7FFFF for ch1 → `rdata`=0x3C while `ack[1]`=1; `n_vwr` never low; `vd` never driven by the DUT.
- Contention: `req`=4'b1110 held → with `SRAM_ARB_RR_EN` the grant order is 1,2,3,1,…; without it, 1,1,1…; adding ch0 mid-sequence makes ch0 the next grant.
- Back-to-back: ch3 holds `req` through 3 accesses → 3 acks, each 5 clks apart (WR_CYC=2), with 1 IDLE clock between accesses.
- Reset mid-STROBE of a write → no `ack`; at that edge `n_vwr`=1, `vd` high-Z and `busy`=0; the next request completes normally.
- WR_CYC=1 and WR_CYC=15 sweep → `n_vwr` low width equals WR_CYC; latency equals 2+WR_CYC.
